// File: rtl/product_bcd_converter_pkg.sv
// Shared widths and FSM state encoding for the product-to-BCD converter.
package Global;

   localparam int DW         = 8;
   localparam int BCD_DIGITS = 5;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

endpackage

// File: rtl/product_bcd_converter_add3.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more.
module Add3_Digit (
   input  logic [3:0] din,
   output logic [3:0] dout
);

   // Pre-shift correction so the digit carries correctly after doubling
   always_comb begin
      dout = din;
      if (din >= 4'd5)
         dout = din + 4'd3;
   end

endmodule

// File: rtl/product_bcd_converter.sv
// Converts a signed 2*DW-bit multiplier product into sign + packed BCD magnitude
// using a shift-and-add-3 sequence of exactly 2*DW shift cycles.
module product_bcd_converter
   import Global::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [2*DW-1:0]         product,
   output logic                    busy,
   output logic                    done,
   output logic                    sign,
   output logic [4*BCD_DIGITS-1:0] bcd
);

   localparam int PW = 2 * DW;
   localparam int BW = 4 * BCD_DIGITS;
   localparam int CW = $clog2(PW + 1);

   state_t          state;
   state_t          next_state;
   logic            start_q;
   logic            start_edge;
   logic            sign_cap;
   logic [PW-1:0]   mag;
   logic [BW-1:0]   work;
   logic [BW-1:0]   work_adj;
   logic [CW-1:0]   cnt;

   assign start_edge = start & ~start_q;

   for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_add3
      Add3_Digit u_add3 (
         .din  (work[4*g +: 4]),
         .dout (work_adj[4*g +: 4])
      );
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst)
         state <= IDLE;
      else
         state <= next_state;
   end

   // Next-state logic and busy flag
   always_comb begin
      next_state = state;
      busy       = 1'b0;
      case (state)
         IDLE: begin
            if (start_edge)
               next_state = SHIFT;
         end
         SHIFT: begin
            busy = 1'b1;
            // counter reaches zero on this shift
            if (cnt == CW'(1))
               next_state = DONE;
         end
         DONE: begin
            busy       = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Datapath: capture, shift-and-correct, and result publication
   always_ff @(posedge clk) begin
      if (!rst) begin
         start_q  <= 1'b0;
         sign_cap <= 1'b0;
         mag      <= '0;
         work     <= '0;
         cnt      <= '0;
         done     <= 1'b0;
         sign     <= 1'b0;
         bcd      <= '0;
      end else begin
         start_q <= start;
         done    <= 1'b0;
         case (state)
            IDLE: begin
               if (start_edge) begin
                  sign_cap <= product[PW-1];
                  // two's-complement negate; -2^(PW-1) maps to 2^(PW-1) unsigned
                  mag      <= product[PW-1] ? (~product + PW'(1)) : product;
                  work     <= '0;
                  cnt      <= CW'(PW);
               end
            end
            SHIFT: begin
               {work, mag} <= {work_adj[BW-2:0], mag, 1'b0};
               cnt         <= cnt - CW'(1);
            end
            DONE: begin
               bcd  <= work;
               sign <= sign_cap;
               done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
